clkdiv_bank: RTL and testbench

Parametrised, multi-channel successor to the single fixed-ratio board clock divider. Generates `NCH` independent divided clocks from the 50 MHz board clock `iclk`. Each channel has:
- a divisor programmable at run time, changed glitch-free at period boundaries;
- a per-channel enable;
- a selectable square-wave or single-pulse output mode;
- a one-cycle tick strobe for use as a clock enable in `iclk`-domain logic.

It sits at the top of the on-board build and feeds the slowed processor clock, display refresh and debounce timing.

---
 rtl/clkdiv_bank.sv | 105 ++++++++++
 tb/tb_clkdiv_bank.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_bank.sv
// Multi-channel programmable clock divider. Each channel has a run-time divisor, an enable,
// square/pulse output modes and a one-cycle wrap strobe. New divisors are applied only at a wrap.
module clkdiv_bank #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CW          = 32,
  parameter int unsigned DEFAULT_DIV = 125000000,
  localparam int unsigned LW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          iclk,
  input  logic          reset,
  input  logic [NCH-1:0] en,
  input  logic          ld,
  input  logic [LW-1:0]  ldch,
  input  logic [CW-1:0]  lddiv,
  input  logic          ldmode,
  output logic [NCH-1:0] oclk,
  output logic [NCH-1:0] otick,
  output logic [NCH-1:0] pend
);

  localparam logic [CW-1:0] DefDiv = CW'(DEFAULT_DIV);

  // Divisors below 2 cannot produce a clock, so they are raised to 2 on every load path.
  logic [CW-1:0] new_div;
  assign new_div = (lddiv < CW'(2)) ? CW'(2) : lddiv;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] div_q, div_d, sdiv_q, sdiv_d, cnt_q, cnt_d, half;
    logic          mode_q, mode_d, smode_q, smode_d;
    logic          pend_q, pend_d, oclk_q, oclk_d, tick_q, tick_d;
    logic          hit, wrap;

    // An out-of-range ldch matches no channel, so the load is dropped.
    assign hit  = ld && (ldch == LW'(i));
    assign wrap = (cnt_q == div_q - CW'(1));

    always_comb begin
      div_d   = div_q;
      mode_d  = mode_q;
      sdiv_d  = sdiv_q;
      smode_d = smode_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      oclk_d  = oclk_q;
      tick_d  = 1'b0;
      half    = '0;
      if (en[i]) begin
        if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (pend_q) begin
            div_d  = sdiv_q;
            mode_d = smode_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        // A load on the wrap edge still lands in the shadow after the old one is consumed.
        if (hit) begin
          sdiv_d  = new_div;
          smode_d = ldmode;
          pend_d  = 1'b1;
        end
        half   = (div_d >> 1) + CW'(div_d[0]);
        oclk_d = mode_d ? (cnt_d == '0) : (cnt_d < half);
      end else if (hit) begin
        div_d   = new_div;
        mode_d  = ldmode;
        sdiv_d  = new_div;
        smode_d = ldmode;
        cnt_d   = new_div - CW'(1);
        oclk_d  = 1'b0;
        pend_d  = 1'b0;
      end
    end

    always_ff @(posedge iclk or posedge reset) begin
      if (reset) begin
        div_q   <= DefDiv;
        mode_q  <= 1'b0;
        sdiv_q  <= DefDiv;
        smode_q <= 1'b0;
        cnt_q   <= DefDiv - CW'(1);
        pend_q  <= 1'b0;
        oclk_q  <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        div_q   <= div_d;
        mode_q  <= mode_d;
        sdiv_q  <= sdiv_d;
        smode_q <= smode_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
        oclk_q  <= oclk_d;
        tick_q  <= tick_d;
      end
    end

    assign oclk[i]  = oclk_q;
    assign otick[i] = tick_q;
    assign pend[i]  = pend_q;
  end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Directed bench for clkdiv_bank: three channels, CW=16, DEFAULT_DIV=4.
module tb_clkdiv_bank;

  logic        iclk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  en = '0;
  logic        ld = 1'b0;
  logic [1:0]  ldch = '0;
  logic [15:0] lddiv = '0;
  logic        ldmode = 1'b0;
  logic [2:0]  oclk, otick, pend;

  int pass_cnt = 0;
  int total_cnt = 0;

  clkdiv_bank #(.NCH(3), .CW(16), .DEFAULT_DIV(4)) dut (
    .iclk(iclk), .reset(reset), .en(en), .ld(ld), .ldch(ldch), .lddiv(lddiv),
    .ldmode(ldmode), .oclk(oclk), .otick(otick), .pend(pend)
  );

  always #5 iclk = ~iclk;

  task automatic step;
    @(posedge iclk);
    #1;
  endtask

  task automatic apply_reset(input logic [2:0] en_v);
    reset = 1'b1;
    en = en_v;
    ld = 1'b0;
    ldch = '0;
    lddiv = '0;
    ldmode = 1'b0;
    step;
    reset = 1'b0;
  endtask

  task automatic load(input logic [1:0] ch, input logic [15:0] d, input logic m);
    ld = 1'b1;
    ldch = ch;
    lddiv = d;
    ldmode = m;
    step;
    ld = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #2;
    total_cnt++;
    if ({oclk, otick, pend} !== 9'b0) $display("FAIL reset_async: got %b required 0", {oclk, otick, pend});
    else pass_cnt++;
    step;
    total_cnt++;
    if ({oclk, otick, pend} !== 9'b0) $display("FAIL reset_held: got %b required 0", {oclk, otick, pend});
    else pass_cnt++;
  endtask

  task automatic test_default;
    logic [2:0] eo, et;
    apply_reset(3'b111);
    for (int k = 0; k < 12; k++) begin
      step;
      eo = (k % 4 < 2) ? 3'b111 : 3'b000;
      et = (k % 4 == 0) ? 3'b111 : 3'b000;
      total_cnt++;
      if (oclk !== eo) $display("FAIL default_oclk edge %0d: got %b required %b", k + 1, oclk, eo);
      else pass_cnt++;
      total_cnt++;
      if (otick !== et) $display("FAIL default_otick edge %0d: got %b required %b", k + 1, otick, et);
      else pass_cnt++;
    end
  endtask

  task automatic test_load_pending;
    logic o0, o1, t0, t1;
    apply_reset(3'b111);
    step;
    step;
    load(2'd1, 16'd5, 1'b0);
    total_cnt++;
    if (pend !== 3'b010) $display("FAIL pend_set: got %b required 010", pend);
    else pass_cnt++;
    total_cnt++;
    if (oclk !== 3'b000) $display("FAIL pend_oclk: got %b required 000", oclk);
    else pass_cnt++;
    step;
    total_cnt++;
    if (pend !== 3'b010) $display("FAIL pend_hold: got %b required 010", pend);
    else pass_cnt++;
    for (int j = 0; j < 10; j++) begin
      step;
      o0 = (j % 4 < 2);
      o1 = (j % 5 < 3);
      t0 = (j % 4 == 0);
      t1 = (j % 5 == 0);
      total_cnt++;
      if (oclk !== {o0, o1, o0}) $display("FAIL newdiv_oclk %0d: got %b required %b", j, oclk, {o0, o1, o0});
      else pass_cnt++;
      total_cnt++;
      if (otick !== {t0, t1, t0}) $display("FAIL newdiv_otick %0d: got %b required %b", j, otick, {t0, t1, t0});
      else pass_cnt++;
      total_cnt++;
      if (pend !== 3'b000) $display("FAIL newdiv_pend %0d: got %b required 000", j, pend);
      else pass_cnt++;
    end
  endtask

  task automatic test_clamp;
    logic [2:0] e;
    apply_reset(3'b000);
    for (int pass = 0; pass < 2; pass++) begin
      en = 3'b000;
      load(2'd2, (pass == 0) ? 16'd0 : 16'd1, 1'b0);
      total_cnt++;
      if ({oclk, otick, pend} !== 9'b0) $display("FAIL clamp_load %0d: got %b required 0", pass, {oclk, otick, pend});
      else pass_cnt++;
      en = 3'b100;
      for (int j = 0; j < 4; j++) begin
        step;
        e = (j % 2 == 0) ? 3'b100 : 3'b000;
        total_cnt++;
        if (oclk !== e) $display("FAIL clamp_oclk %0d/%0d: got %b required %b", pass, j, oclk, e);
        else pass_cnt++;
        total_cnt++;
        if (otick !== e) $display("FAIL clamp_otick %0d/%0d: got %b required %b", pass, j, otick, e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_pulse;
    logic p, o0, t0;
    apply_reset(3'b000);
    load(2'd2, 16'd3, 1'b1);
    en = 3'b111;
    for (int j = 0; j < 12; j++) begin
      step;
      p = (j % 3 == 0);
      o0 = (j % 4 < 2);
      t0 = (j % 4 == 0);
      total_cnt++;
      if (oclk !== {p, o0, o0}) $display("FAIL pulse_oclk %0d: got %b required %b", j, oclk, {p, o0, o0});
      else pass_cnt++;
      total_cnt++;
      if (otick !== {p, t0, t0}) $display("FAIL pulse_otick %0d: got %b required %b", j, otick, {p, t0, t0});
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    logic eo, et, ep;
    apply_reset(3'b111);
    step;
    load(2'd0, 16'd6, 1'b0);
    total_cnt++;
    if (pend[0] !== 1'b1) $display("FAIL b2b_first_pend: got %b required 1", pend[0]);
    else pass_cnt++;
    step;
    step;
    load(2'd0, 16'd3, 1'b0);
    for (int j = 0; j < 12; j++) begin
      if (j > 0) step;
      if (j < 6) begin
        eo = (j < 3);
        et = (j == 0);
        ep = 1'b1;
      end else begin
        eo = ((j - 6) % 3 < 2);
        et = ((j - 6) % 3 == 0);
        ep = 1'b0;
      end
      total_cnt++;
      if ({oclk[0], otick[0], pend[0]} !== {eo, et, ep})
        $display("FAIL b2b %0d: got oclk/otick/pend %b required %b", j, {oclk[0], otick[0], pend[0]}, {eo, et, ep});
      else pass_cnt++;
    end
  endtask

  task automatic test_enable_hold;
    apply_reset(3'b111);
    step;
    step;
    en = 3'b110;
    for (int j = 0; j < 10; j++) begin
      step;
      total_cnt++;
      if ({oclk[0], otick[0]} !== 2'b10) $display("FAIL hold %0d: got %b required 10", j, {oclk[0], otick[0]});
      else pass_cnt++;
    end
    en = 3'b111;
    for (int j = 0; j < 3; j++) begin
      step;
      total_cnt++;
      if ({oclk[0], otick[0]} !== ((j == 2) ? 2'b11 : 2'b00))
        $display("FAIL resume %0d: got %b required %b", j, {oclk[0], otick[0]}, (j == 2) ? 2'b11 : 2'b00);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    load(2'd2, 16'd7, 1'b0);
    total_cnt++;
    if (pend !== 3'b100 || oclk[0] !== 1'b1) $display("FAIL pre_reset: got pend %b oclk %b required 100/xx1", pend, oclk);
    else pass_cnt++;
    #3 reset = 1'b1;
    #1;
    total_cnt++;
    if ({oclk, otick, pend} !== 9'b0) $display("FAIL mid_reset: got %b required 0", {oclk, otick, pend});
    else pass_cnt++;
    step;
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step;
      total_cnt++;
      if ({oclk[2], pend[2]} !== {(j % 4 < 2), 1'b0})
        $display("FAIL post_reset %0d: got %b required %b", j, {oclk[2], pend[2]}, {(j % 4 < 2), 1'b0});
      else pass_cnt++;
    end
  endtask

  task automatic test_bad_channel;
    logic [2:0] eo;
    apply_reset(3'b000);
    load(2'd3, 16'd2, 1'b1);
    total_cnt++;
    if ({oclk, pend} !== 6'b0) $display("FAIL bad_ch_load: got %b required 0", {oclk, pend});
    else pass_cnt++;
    en = 3'b111;
    for (int j = 0; j < 8; j++) begin
      step;
      eo = (j % 4 < 2) ? 3'b111 : 3'b000;
      total_cnt++;
      if (oclk !== eo) $display("FAIL bad_ch_oclk %0d: got %b required %b", j, oclk, eo);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_default;
    test_load_pending;
    test_clamp;
    test_pulse;
    test_back_to_back;
    test_enable_hold;
    test_reset_mid;
    test_bad_channel;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
